// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: RV32 instruction fetch stage.
// Holds the fetch PC and issues word requests to instruction memory. Requests
// are issued only while free credit remains, so the DEPTH-entry queue can never
// overflow. In-order responses are buffered and handed to decode as {pc, instr}
// pairs. A redirect flushes the queue and marks every in-flight request so that
// its response is discarded.
module fetch_queue_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req_valid,
    output logic [31:0]      imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             dec_valid,
    output logic [31:0]      dec_instr,
    output logic [31:0]      dec_pc,
    input  logic             dec_ready,
    output logic [CNT_W-1:0] queue_count
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam int unsigned      SUM_W    = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_W  = SUM_W'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [0:0] {
        ST_HOLD  = 1'b0,
        ST_FETCH = 1'b1
    } state_e;

    // Registered state
    state_e           state_r;
    logic [31:0]      fetch_pc_r;
    logic [31:0]      rsp_pc_r;
    logic [CNT_W-1:0] outst_r;
    logic [CNT_W-1:0] drop_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [31:0]      q_instr_r [DEPTH];
    logic [31:0]      q_pc_r    [DEPTH];

    // Combinational control
    logic [SUM_W-1:0] credit_s;
    logic             req_valid_s;
    logic             accept_s;
    logic             dec_valid_s;
    logic             pop_s;
    logic             keep_s;
    logic             push_s;
    logic [CNT_W-1:0] outst_next_s;
    logic [31:0]      redirect_pc_s;
    logic             unused_ok_s;

    // Handshake decisions derived from registered state and this cycle's inputs.
    always_comb begin
        credit_s      = SUM_W'(count_r) + SUM_W'(outst_r);
        req_valid_s   = (state_r == ST_FETCH) && (credit_s < DEPTH_W);
        accept_s      = req_valid_s && imem_req_ready;
        dec_valid_s   = (count_r != CNT_ZERO);
        // A redirect flushes the queue, so a pop in that cycle has no effect.
        pop_s         = dec_valid_s && dec_ready && !redirect_valid;
        // Responses are discarded while stale requests are being retired or
        // while a redirect is taking effect.
        keep_s        = imem_rsp_valid && !redirect_valid && (drop_r == CNT_ZERO);
        push_s        = keep_s && ((count_r != DEPTH_C) || pop_s);
        outst_next_s  = outst_r + CNT_W'(accept_s) - CNT_W'(imem_rsp_valid);
        redirect_pc_s = {redirect_pc[31:2], 2'b00};
        unused_ok_s   = ^redirect_pc[1:0];
    end

    // Output drive: request and decode ports read straight from registered state.
    always_comb begin
        imem_req_valid = req_valid_s;
        imem_req_addr  = (state_r == ST_FETCH) ? fetch_pc_r : 32'h0000_0000;
        dec_valid      = dec_valid_s;
        dec_instr      = dec_valid_s ? q_instr_r[head_r] : 32'h0000_0000;
        dec_pc         = dec_valid_s ? q_pc_r[head_r]    : 32'h0000_0000;
        queue_count    = count_r;
    end

    // Control state: FSM, PCs, credit tracking, drop counter and queue pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_HOLD;
            fetch_pc_r <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
            outst_r    <= CNT_ZERO;
            drop_r     <= CNT_ZERO;
            count_r    <= CNT_ZERO;
            head_r     <= PTR_ZERO;
            tail_r     <= PTR_ZERO;
        end else begin
            case (state_r)
                ST_HOLD:  state_r <= ST_FETCH;
                ST_FETCH: state_r <= ST_FETCH;
                default:  state_r <= ST_HOLD;
            endcase

            outst_r <= outst_next_s;

            if (redirect_valid) begin
                // Everything still in flight after this edge is stale.
                fetch_pc_r <= redirect_pc_s;
                rsp_pc_r   <= redirect_pc_s;
                drop_r     <= outst_next_s;
                count_r    <= CNT_ZERO;
                head_r     <= PTR_ZERO;
                tail_r     <= PTR_ZERO;
            end else begin
                if (accept_s) begin
                    fetch_pc_r <= fetch_pc_r + 32'd4;
                end
                if (push_s) begin
                    rsp_pc_r <= rsp_pc_r + 32'd4;
                    tail_r   <= tail_r + PTR_ONE;
                end
                if (imem_rsp_valid && (drop_r != CNT_ZERO)) begin
                    drop_r <= drop_r - CNT_ONE;
                end
                if (pop_s) begin
                    head_r <= head_r + PTR_ONE;
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // Queue storage: written at the tail on every kept response.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_instr_r[tail_r] <= imem_rsp_data;
            q_pc_r[tail_r]    <= rsp_pc_r;
        end
    end

endmodule
